// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that time-shares one WIDTH-bit register between N requesters.
// Each grant loads the winner's word, then the register is held for HOLD_CYC cycles.
module shared_reg_arbiter #(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int HOLD_CYC = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [N-1:0]                           req,
    input  logic [N*WIDTH-1:0]                     wdata,
    output logic [WIDTH-1:0]                       q,
    output logic [N-1:0]                           gnt,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0]     owner,
    output logic                                   busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [IW-1:0]     last_reg, last_next;
    logic [IW-1:0]     owner_reg, owner_next;
    logic [WIDTH-1:0]  q_reg, q_next;
    logic [N-1:0]      gnt_reg, gnt_next;
    logic              busy_reg, busy_next;

    logic [WIDTH-1:0]  word [N];
    logic [N-1:0]      win_onehot;
    logic [IW-1:0]     win_idx;
    logic [IW-1:0]     scan;
    logic              found;
    logic [WIDTH-1:0]  word_sel;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(N - 1)) ? '0 : i + 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign word[gi]       = wdata[gi*WIDTH +: WIDTH];
            assign win_onehot[gi] = found && (win_idx == IW'(gi));
        end
    endgenerate

    // Scan starts one past the last winner and wraps, giving rotating priority.
    always_comb begin
        scan    = next_idx(last_reg);
        found   = 1'b0;
        win_idx = last_reg;
        for (int k = 0; k < N; k++) begin
            if (!found && req[scan]) begin
                found   = 1'b1;
                win_idx = scan;
            end
            scan = next_idx(scan);
        end
    end

    // AND-OR select so only the winner's word can reach the register.
    always_comb begin
        word_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (win_onehot[i]) begin
                word_sel = word_sel | word[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        last_next  = last_reg;
        owner_next = owner_reg;
        q_next     = q_reg;
        gnt_next   = '0;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    q_next     = word_sel;
                    gnt_next   = win_onehot;
                    owner_next = win_idx;
                    last_next  = win_idx;
                    if (HOLD_CYC > 0) begin
                        state_next = HOLD;
                        cnt_next   = 4'(HOLD_CYC);
                    end
                end
            end
            HOLD: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        busy_next = (state_next == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            last_reg  <= IW'(N - 1);
            owner_reg <= '0;
            q_reg     <= '0;
            gnt_reg   <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            last_reg  <= last_next;
            owner_reg <= owner_next;
            q_reg     <= q_next;
            gnt_reg   <= gnt_next;
            busy_reg  <= busy_next;
        end
    end

    assign q     = q_reg;
    assign gnt   = gnt_reg;
    assign owner = owner_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: one instance with HOLD_CYC=2, one with HOLD_CYC=0.
module tb_shared_reg_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  req0;
    logic [31:0] wdata;
    logic [7:0]  q, q0;
    logic [3:0]  gnt, gnt0;
    logic [1:0]  owner, owner0;
    logic        busy, busy0;

    int checks = 0;
    int errors = 0;

    shared_reg_arbiter #(.N(4), .WIDTH(8), .HOLD_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
        .q(q), .gnt(gnt), .owner(owner), .busy(busy)
    );

    shared_reg_arbiter #(.N(4), .WIDTH(8), .HOLD_CYC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .wdata(wdata),
        .q(q0), .gnt(gnt0), .owner(owner0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] eq, input logic [3:0] eg,
                             input logic [1:0] eo, input logic eb);
        check({tag, ".q"}, 32'(q), 32'(eq));
        check({tag, ".gnt"}, 32'(gnt), 32'(eg));
        check({tag, ".owner"}, 32'(owner), 32'(eo));
        check({tag, ".busy"}, 32'(busy), 32'(eb));
        $display("step %-14s q=%02h gnt=%b owner=%0d busy=%0d", tag, q, gnt, owner, busy);
    endtask

    logic [1:0] rr_seq [5];
    logic [7:0] rr_q   [5];

    initial begin
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_q   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

        rst_n = 1'b1;
        req   = 4'b0000;
        req0  = 4'b0000;
        wdata = 32'h0;

        // asynchronous reset mid-cycle, checked before any clock edge
        #3 rst_n = 1'b0;
        #1 check_all("reset_async", 8'h00, 4'b0000, 2'd0, 1'b0);
        check("reset_async.busy0", 32'(busy0), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_all("idle_noreq", 8'h00, 4'b0000, 2'd0, 1'b0);
        end

        // single write
        wdata = 32'h000000A5;
        req   = 4'b0001;
        tick();
        check_all("single_E0", 8'hA5, 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        tick();
        check_all("single_E1", 8'hA5, 4'b0000, 2'd0, 1'b1);
        tick();
        check_all("single_E2", 8'hA5, 4'b0000, 2'd0, 1'b0);
        tick();
        check_all("single_E3", 8'hA5, 4'b0000, 2'd0, 1'b0);

        // re-reset away from the edge so the pointer restarts at requester 0
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;

        // round robin with all requesters active
        wdata = 32'h13121110;
        req   = 4'b1111;
        for (int c = 0; c < 13; c++) begin
            tick();
            if (c % 3 == 0) begin
                check_all("rr_grant", rr_q[c/3], 4'(1 << rr_seq[c/3]), rr_seq[c/3], 1'b1);
            end else begin
                check("rr_gap.gnt", 32'(gnt), 32'd0);
            end
        end

        // requester 2 wins (pointer was 0, scan 1->2)
        req = 4'b0100;
        tick();
        tick();
        tick();
        check_all("wrap_r2", 8'h12, 4'b0100, 2'd2, 1'b1);

        // pointer now 2: scan 3 -> 0 picks requester 0
        req = 4'b0101;
        tick();
        check("wrap_hold1.gnt", 32'(gnt), 32'd0);
        tick();
        check("wrap_hold2.gnt", 32'(gnt), 32'd0);
        tick();
        check_all("wrap_r0", 8'h10, 4'b0001, 2'd0, 1'b1);

        req = 4'b0100;
        tick();
        tick();
        tick();
        check_all("prio_r2", 8'h12, 4'b0100, 2'd2, 1'b1);

        // one-cycle request during HOLD is ignored
        req = 4'b1000;
        tick();
        check_all("mask_h1", 8'h12, 4'b0000, 2'd2, 1'b1);
        req = 4'b0000;
        tick();
        check_all("mask_h2", 8'h12, 4'b0000, 2'd2, 1'b0);
        tick();
        check_all("mask_idle", 8'h12, 4'b0000, 2'd2, 1'b0);

        // reset in the middle of HOLD
        wdata = 32'h13125A10;
        req   = 4'b0010;
        tick();
        check_all("pre_rst_grant", 8'h5A, 4'b0010, 2'd1, 1'b1);
        req = 4'b0000;
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all("rst_midhold", 8'h00, 4'b0000, 2'd0, 1'b0);
        #1 rst_n = 1'b1;
        wdata = 32'h33225A00;
        req   = 4'b1110;
        tick();
        check_all("post_rst_r1", 8'h5A, 4'b0010, 2'd1, 1'b1);
        req = 4'b0000;

        // HOLD_CYC=0: back-to-back alternating grants
        wdata = 32'h0000BBAA;
        req0  = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("b2b.gnt", 32'(gnt0), (c % 2 == 0) ? 32'd1 : 32'd2);
            check("b2b.q", 32'(q0), (c % 2 == 0) ? 32'hAA : 32'hBB);
            check("b2b.busy", 32'(busy0), 32'd0);
            $display("step b2b_%0d gnt=%b q=%02h busy=%0d", c, gnt0, q0, busy0);
        end
        req0 = 4'b0000;
        tick();
        check("b2b_stop.gnt", 32'(gnt0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
